// File: rtl/rotation_ascii_encoder_if.sv
// Command-in / byte-out bundle for the rotation ASCII encoder.
// The master side is the command source and byte sink; the slave side is the encoder.
interface rotation_ascii_encoder_if #(
  parameter int unsigned STEPS_WIDTH = 10
) ();

  logic                   cmd_ccw;
  logic [STEPS_WIDTH-1:0] cmd_steps;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [7:0]             ascii_data;
  logic                   ascii_valid;
  logic                   ascii_ready;
  logic                   range_error;

  modport master (
    output cmd_ccw,
    output cmd_steps,
    output cmd_valid,
    input  cmd_ready,
    input  ascii_data,
    input  ascii_valid,
    output ascii_ready,
    input  range_error
  );

  modport slave (
    input  cmd_ccw,
    input  cmd_steps,
    input  cmd_valid,
    output cmd_ready,
    output ascii_data,
    output ascii_valid,
    input  ascii_ready,
    output range_error
  );

endinterface

// File: rtl/rotation_ascii_encoder.sv
// Serialises one dial-rotation command into "L"/"R", a zero-suppressed decimal
// step count and LF, converting the count with a bit-serial double-dabble.
module rotation_ascii_encoder #(
  parameter int unsigned STEPS_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  rotation_ascii_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StConvert,
    StEmitDir,
    StEmitDigits,
    StEmitLf
  } state_e;

  localparam logic [7:0] CharL  = 8'h4C;
  localparam logic [7:0] CharR  = 8'h52;
  localparam logic [7:0] CharLf = 8'h0A;

  state_e      state_q;
  logic        ccw_q;
  logic [9:0]  bin_q;
  logic [11:0] bcd_q;
  logic [3:0]  cnt_q;
  logic [1:0]  dig_q;
  logic        cmd_ready_q;
  logic        ascii_valid_q;
  logic [7:0]  ascii_data_q;
  logic        range_error_q;

  logic        over_range;
  logic [9:0]  steps_clamped;
  logic [11:0] bcd_adj;
  logic [21:0] dd_shifted;
  logic [11:0] bcd_d;
  logic [9:0]  bin_d;
  logic        transfer;

  assign over_range    = bus.cmd_steps > STEPS_WIDTH'(999);
  assign steps_clamped = over_range ? 10'd999 : bus.cmd_steps[9:0];
  assign transfer      = ascii_valid_q && bus.ascii_ready;

  // One double-dabble iteration: add 3 to any digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
    dd_shifted = {bcd_adj, bin_q} << 1;
    bcd_d      = dd_shifted[21:10];
    bin_d      = dd_shifted[9:0];
  end

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return {4'h3, d};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      ccw_q         <= 1'b0;
      bin_q         <= '0;
      bcd_q         <= '0;
      cnt_q         <= '0;
      dig_q         <= '0;
      cmd_ready_q   <= 1'b1;
      ascii_valid_q <= 1'b0;
      ascii_data_q  <= 8'h00;
      range_error_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            ccw_q       <= bus.cmd_ccw;
            bin_q       <= steps_clamped;
            bcd_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= StConvert;
            if (over_range) begin
              range_error_q <= 1'b1;
            end
          end
        end

        StConvert: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd9) begin
            state_q       <= StEmitDir;
            ascii_valid_q <= 1'b1;
            ascii_data_q  <= ccw_q ? CharL : CharR;
          end
        end

        // Leading-zero suppression picks the first digit to present.
        StEmitDir: begin
          if (transfer) begin
            state_q <= StEmitDigits;
            if (bcd_q[11:8] != 4'd0) begin
              dig_q        <= 2'd2;
              ascii_data_q <= digit_char(bcd_q[11:8]);
            end else if (bcd_q[7:4] != 4'd0) begin
              dig_q        <= 2'd1;
              ascii_data_q <= digit_char(bcd_q[7:4]);
            end else begin
              dig_q        <= 2'd0;
              ascii_data_q <= digit_char(bcd_q[3:0]);
            end
          end
        end

        StEmitDigits: begin
          if (transfer) begin
            if (dig_q == 2'd0) begin
              state_q      <= StEmitLf;
              ascii_data_q <= CharLf;
            end else if (dig_q == 2'd2) begin
              dig_q        <= 2'd1;
              ascii_data_q <= digit_char(bcd_q[7:4]);
            end else begin
              dig_q        <= 2'd0;
              ascii_data_q <= digit_char(bcd_q[3:0]);
            end
          end
        end

        StEmitLf: begin
          if (transfer) begin
            state_q       <= StIdle;
            ascii_valid_q <= 1'b0;
            ascii_data_q  <= 8'h00;
            cmd_ready_q   <= 1'b1;
          end
        end

        default: begin
          state_q       <= StIdle;
          ascii_valid_q <= 1'b0;
          ascii_data_q  <= 8'h00;
          cmd_ready_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.ascii_valid = ascii_valid_q;
  assign bus.ascii_data  = ascii_data_q;
  assign bus.range_error = range_error_q;

endmodule

// File: tb/tb_rotation_ascii_encoder.sv
// Directed bench for rotation_ascii_encoder: frame contents, latency, backpressure,
// queued commands, clamping and mid-frame reset.
module tb_rotation_ascii_encoder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  rotation_ascii_encoder_if #(.STEPS_WIDTH(10)) bus ();

  rotation_ascii_encoder #(.STEPS_WIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents one command, then checks cmd_ready drop, range flag and 10-edge latency.
  task automatic send_cmd(input logic ccw, input int steps, input logic exp_range,
                          input string tag);
    int  w;
    bit  early;
    w     = 0;
    early = 1'b0;
    while (bus.cmd_ready !== 1'b1 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk({tag, "_ready_before"}, bus.cmd_ready, 1);
    bus.cmd_ccw   = ccw;
    bus.cmd_steps = 10'(steps);
    bus.cmd_valid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_ccw   = ~ccw;
    bus.cmd_steps = 10'h155;
    chk({tag, "_ready_drop"}, bus.cmd_ready, 0);
    chk({tag, "_range"}, bus.range_error, exp_range);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.ascii_valid !== 1'b0) early = 1'b1;
    end
    chk({tag, "_no_early_valid"}, early, 0);
    @(posedge clk); #1;
    chk({tag, "_valid_at_10"}, bus.ascii_valid, 1);
    chk({tag, "_dir_byte"}, bus.ascii_data, ccw ? 8'h4C : 8'h52);
  endtask

  // Drains one frame with an optional ascii_ready pattern (bit i = cycle i, then 1).
  task automatic collect(input string exp, input logic [15:0] pat, input int plen,
                         input string tag);
    int         k;
    int         cyc;
    bit         stalled;
    bit         done;
    logic       rdy;
    logic [7:0] held;
    k       = 0;
    cyc     = 0;
    stalled = 1'b0;
    done    = 1'b0;
    held    = 8'h00;
    while (!done && cyc < 40) begin
      rdy = (cyc < plen) ? pat[cyc] : 1'b1;
      bus.ascii_ready = rdy;
      if (stalled) begin
        chk({tag, "_hold_valid"}, bus.ascii_valid, 1);
        chk({tag, "_hold_data"}, bus.ascii_data, held);
      end
      chk({tag, "_cmd_ready_busy"}, bus.cmd_ready, 0);
      if (bus.ascii_valid === 1'b1 && rdy) begin
        if (k < exp.len()) chk({tag, "_byte"}, bus.ascii_data, exp[k]);
        k++;
        if (k >= exp.len()) done = 1'b1;
        stalled = 1'b0;
      end else if (bus.ascii_valid === 1'b1) begin
        stalled = 1'b1;
        held    = bus.ascii_data;
      end else begin
        chk({tag, "_valid_in_frame"}, bus.ascii_valid, 1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_frame_done"}, done, 1);
    chk({tag, "_ready_after_lf"}, bus.cmd_ready, 1);
    chk({tag, "_valid_after_lf"}, bus.ascii_valid, 0);
    chk({tag, "_data_idle"}, bus.ascii_data, 8'h00);
    bus.ascii_ready = 1'b1;
  endtask

  initial begin
    string      qexp;
    int         qk;
    int         qidx;
    bit         acc;
    bit         quiet;
    logic       qccw  [3];
    int         qsteps[3];

    n_checks        = 0;
    n_fail          = 0;
    rst             = 1'b1;
    bus.cmd_ccw     = 1'b0;
    bus.cmd_steps   = '0;
    bus.cmd_valid   = 1'b0;
    bus.ascii_ready = 1'b1;

    #3;
    chk("rst_cmd_ready", bus.cmd_ready, 1);
    chk("rst_valid", bus.ascii_valid, 0);
    chk("rst_data", bus.ascii_data, 8'h00);
    chk("rst_range", bus.range_error, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    send_cmd(1'b0, 12, 1'b0, "r12");
    collect("R12\n", 16'h0, 0, "r12");
    chk("r12_range_after", bus.range_error, 0);

    send_cmd(1'b1, 0, 1'b0, "l0");
    collect("L0\n", 16'h0, 0, "l0");

    send_cmd(1'b1, 100, 1'b0, "l100");
    collect("L100\n", 16'h0, 0, "l100");

    send_cmd(1'b0, 1023, 1'b1, "r1023");
    collect("R999\n", 16'h0, 0, "r1023");

    send_cmd(1'b0, 5, 1'b1, "r5");
    collect("R5\n", 16'h0, 0, "r5");
    chk("r5_range_sticky", bus.range_error, 1);

    // ascii_ready sequence 0,0,1,0,1,1,1
    send_cmd(1'b0, 47, 1'b1, "r47");
    collect("R47\n", 16'h0074, 7, "r47_bp");

    // Three commands offered back to back with cmd_valid held high.
    qccw[0] = 1'b1; qsteps[0] = 68;
    qccw[1] = 1'b0; qsteps[1] = 30;
    qccw[2] = 1'b1; qsteps[2] = 5;
    qexp = "L68\nR30\nL5\n";
    qk   = 0;
    qidx = 0;
    bus.ascii_ready = 1'b1;
    bus.cmd_ccw     = qccw[0];
    bus.cmd_steps   = 10'(qsteps[0]);
    bus.cmd_valid   = 1'b1;
    for (int cyc = 0; cyc < 200 && qk < qexp.len(); cyc++) begin
      acc = (bus.cmd_ready === 1'b1) && bus.cmd_valid;
      if (acc) chk("queue_accept_idle", bus.ascii_valid, 0);
      if (bus.ascii_valid === 1'b1) begin
        chk("queue_byte", bus.ascii_data, qexp[qk]);
        qk++;
      end
      @(posedge clk); #1;
      if (acc) begin
        qidx++;
        if (qidx < 3) begin
          bus.cmd_ccw   = qccw[qidx];
          bus.cmd_steps = 10'(qsteps[qidx]);
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
    end
    bus.cmd_valid = 1'b0;
    chk("queue_bytes_total", qk, qexp.len());
    chk("queue_accepts", qidx, 3);
    @(posedge clk); #1;
    chk("queue_idle_after", bus.cmd_ready, 1);

    // Reset while the tens digit of R/256 is on the bus.
    send_cmd(1'b0, 256, 1'b1, "r256");
    bus.ascii_ready = 1'b1;
    @(posedge clk); #1;
    chk("r256_hundreds", bus.ascii_data, 8'h32);
    @(posedge clk); #1;
    chk("r256_tens", bus.ascii_data, 8'h35);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.ascii_valid, 0);
    chk("async_rst_data", bus.ascii_data, 8'h00);
    chk("async_rst_cmd_ready", bus.cmd_ready, 1);
    chk("async_rst_range", bus.range_error, 0);
    @(posedge clk); #1;
    rst   = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.ascii_valid !== 1'b0) quiet = 1'b0;
      @(posedge clk); #1;
    end
    chk("no_lf_after_rst", quiet, 1);
    chk("idle_after_rst", bus.cmd_ready, 1);

    send_cmd(1'b0, 7, 1'b0, "r7");
    collect("R7\n", 16'h0, 0, "r7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
